// File: rtl/tow_pkg.sv
// Shared types and helpers for the tug-of-war playfield: FSM state encoding
// plus centre-position and score-ceiling calculations.
package tow_pkg;

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    WIN_L      = 2'd1,
    WIN_R      = 2'd2,
    MATCH_OVER = 2'd3
  } tow_state_e;

  function automatic int unsigned center_pos(input int unsigned n_lights);
    return (n_lights - 32'd1) / 32'd2;
  endfunction

  function automatic int unsigned score_max(input int unsigned score_w);
    return (32'd1 << score_w) - 32'd1;
  endfunction

endpackage

// File: rtl/tug_of_war_field_if.sv
// Player-facing bundle: press pulses in, playfield display and scoreboard out.
interface tug_of_war_field_if #(
  parameter int unsigned N_LIGHTS = 9,
  parameter int unsigned SCORE_W  = 3
);

  logic                L;
  logic                R;
  logic                new_round;
  logic [N_LIGHTS-1:0] lights;
  logic                win_l;
  logic                win_r;
  logic [SCORE_W-1:0]  score_l;
  logic [SCORE_W-1:0]  score_r;
  logic                match_over;

  modport master (
    output L, R, new_round,
    input  lights, win_l, win_r, score_l, score_r, match_over
  );

  modport slave (
    input  L, R, new_round,
    output lights, win_l, win_r, score_l, score_r, match_over
  );

endinterface

// File: rtl/sat_counter.sv
// Per-player round counter that stops at its all-ones ceiling and flags it.
module sat_counter
  import tow_pkg::*;
#(
  parameter int unsigned SCORE_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc_i,
  output logic [SCORE_W-1:0] value_o,
  output logic               sat_o
);

  localparam logic [SCORE_W-1:0] MAX_VAL = SCORE_W'(score_max(SCORE_W));

  logic [SCORE_W-1:0] value_q, value_d;
  logic               sat_q, sat_d;

  always_comb begin
    value_d = value_q;
    if (inc_i && !sat_q) begin
      value_d = value_q + SCORE_W'(1);
    end
    sat_d = (value_d == MAX_VAL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      sat_q   <= sat_d;
    end
  end

  assign value_o = value_q;
  assign sat_o   = sat_q;

endmodule

// File: rtl/tug_of_war_field.sv
// Tug-of-war playfield: presses walk a single light left/right, pushing it off
// an edge wins the round; first player to a full score wins the match.
module tug_of_war_field
  import tow_pkg::*;
#(
  parameter int unsigned N_LIGHTS    = 9,
  parameter int unsigned SCORE_W     = 3,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  tug_of_war_field_if.slave  bus
);

  localparam int unsigned POS_W  = $clog2(N_LIGHTS);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [POS_W-1:0]    CENTER        = POS_W'(center_pos(N_LIGHTS));
  localparam logic [POS_W-1:0]    POS_MAX       = POS_W'(N_LIGHTS - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST     = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0]  SCORE_PRE_MAX = SCORE_W'(score_max(SCORE_W) - 1);
  localparam logic [N_LIGHTS-1:0] LIGHTS_CENTER = N_LIGHTS'(1) << center_pos(N_LIGHTS);

  tow_state_e          state_q, state_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [N_LIGHTS-1:0] lights_q, lights_d;
  logic                win_l_q, win_l_d;
  logic                win_r_q, win_r_d;
  logic                match_over_q, match_over_d;

  logic                inc_l_c, inc_r_c;
  logic [SCORE_W-1:0]  score_l, score_r;
  logic                sat_l, sat_r;
  logic                l_only_c, r_only_c;

  // Simultaneous presses cancel each other out.
  assign l_only_c = bus.L & ~bus.R;
  assign r_only_c = bus.R & ~bus.L;

  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    hold_d       = hold_q;
    inc_l_c      = 1'b0;
    inc_r_c      = 1'b0;
    win_l_d      = 1'b0;
    win_r_d      = 1'b0;
    match_over_d = 1'b0;
    lights_d     = '0;

    case (state_q)
      PLAY: begin
        if (bus.new_round) begin
          pos_d = CENTER;
        end else if (l_only_c) begin
          if (pos_q == POS_MAX) begin
            inc_l_c = 1'b1;
            hold_d  = '0;
            state_d = (score_l == SCORE_PRE_MAX) ? MATCH_OVER : WIN_L;
          end else begin
            pos_d = pos_q + POS_W'(1);
          end
        end else if (r_only_c) begin
          if (pos_q == '0) begin
            inc_r_c = 1'b1;
            hold_d  = '0;
            state_d = (score_r == SCORE_PRE_MAX) ? MATCH_OVER : WIN_R;
          end else begin
            pos_d = pos_q - POS_W'(1);
          end
        end
      end
      WIN_L, WIN_R: begin
        if (bus.new_round || (hold_q == HOLD_LAST)) begin
          state_d = PLAY;
          pos_d   = CENTER;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
      end
    endcase

    // Outputs are decoded from the next state so they land with it.
    if (state_d == MATCH_OVER) begin
      win_l_d = (state_q == MATCH_OVER) ? sat_l : inc_l_c;
      win_r_d = (state_q == MATCH_OVER) ? sat_r : inc_r_c;
    end else begin
      win_l_d = (state_d == WIN_L);
      win_r_d = (state_d == WIN_R);
    end
    match_over_d = (state_d == MATCH_OVER);

    if (state_d == PLAY) begin
      lights_d[pos_d] = 1'b1;
    end else if (state_d == MATCH_OVER) begin
      lights_d = '1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= PLAY;
      pos_q        <= CENTER;
      hold_q       <= '0;
      lights_q     <= LIGHTS_CENTER;
      win_l_q      <= 1'b0;
      win_r_q      <= 1'b0;
      match_over_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      hold_q       <= hold_d;
      lights_q     <= lights_d;
      win_l_q      <= win_l_d;
      win_r_q      <= win_r_d;
      match_over_q <= match_over_d;
    end
  end

  sat_counter #(.SCORE_W(SCORE_W)) u_score_l (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (inc_l_c),
    .value_o (score_l),
    .sat_o   (sat_l)
  );

  sat_counter #(.SCORE_W(SCORE_W)) u_score_r (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (inc_r_c),
    .value_o (score_r),
    .sat_o   (sat_r)
  );

  assign bus.lights     = lights_q;
  assign bus.win_l      = win_l_q;
  assign bus.win_r      = win_r_q;
  assign bus.score_l    = score_l;
  assign bus.score_r    = score_r;
  assign bus.match_over = match_over_q;

endmodule

// File: tb/tb_tug_of_war_field.sv
// Directed bench for tug_of_war_field with N_LIGHTS=9, SCORE_W=3, HOLD_CYCLES=16.
module tb_tug_of_war_field;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  tug_of_war_field_if #(.N_LIGHTS(9), .SCORE_W(3)) bus ();

  tug_of_war_field #(
    .N_LIGHTS    (9),
    .SCORE_W     (3),
    .HOLD_CYCLES (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [8:0] lights, input logic wl,
                           input logic wr, input logic [2:0] sl, input logic [2:0] sr,
                           input logic mo);
    chk({tag, ".lights"},     32'(bus.lights),     32'(lights));
    chk({tag, ".win_l"},      32'(bus.win_l),      32'(wl));
    chk({tag, ".win_r"},      32'(bus.win_r),      32'(wr));
    chk({tag, ".score_l"},    32'(bus.score_l),    32'(sl));
    chk({tag, ".score_r"},    32'(bus.score_r),    32'(sr));
    chk({tag, ".match_over"}, 32'(bus.match_over), 32'(mo));
  endtask

  task automatic press(input logic l, input logic r, input logic nr);
    @(negedge clk);
    bus.L = l; bus.R = r; bus.new_round = nr;
    @(posedge clk);
    #1;
    bus.L = 1'b0; bus.R = 1'b0; bus.new_round = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.L = 1'b0; bus.R = 1'b0; bus.new_round = 1'b0;
    #3 reset = 1'b0;
    #9;
    check_all("in_reset", 9'h010, 0, 0, 3'd0, 3'd0, 0);
    @(negedge clk) reset = 1'b1;
    idle(1);
    check_all("post_reset", 9'h010, 0, 0, 3'd0, 3'd0, 0);

    // Walk left to the edge, then win.
    press(1, 0, 0); chk("l1", 32'(bus.lights), 32'h020);
    press(1, 0, 0); chk("l2", 32'(bus.lights), 32'h040);
    press(1, 0, 0); chk("l3", 32'(bus.lights), 32'h080);
    press(1, 0, 0); chk("l4", 32'(bus.lights), 32'h100);
    press(1, 0, 0);
    check_all("win_l", 9'h000, 1, 0, 3'd1, 3'd0, 0);
    idle(15);
    check_all("hold15", 9'h000, 1, 0, 3'd1, 3'd0, 0);
    idle(1);
    check_all("hold_done", 9'h010, 0, 0, 3'd1, 3'd0, 0);

    // Cancel, then new_round overriding L.
    press(1, 1, 0); chk("cancel", 32'(bus.lights), 32'h010);
    press(1, 0, 0);
    press(1, 0, 0); chk("pos6", 32'(bus.lights), 32'h040);
    press(1, 0, 1);
    check_all("nr_play", 9'h010, 0, 0, 3'd1, 3'd0, 0);

    // Walk right to a win, then cut the hold short.
    press(0, 1, 0); chk("r1", 32'(bus.lights), 32'h008);
    press(0, 1, 0); chk("r2", 32'(bus.lights), 32'h004);
    press(0, 1, 0); chk("r3", 32'(bus.lights), 32'h002);
    press(0, 1, 0); chk("r4", 32'(bus.lights), 32'h001);
    press(0, 1, 0);
    check_all("win_r", 9'h000, 0, 1, 3'd1, 3'd1, 0);
    idle(1);
    press(1, 0, 0);
    check_all("win_r_ignore_l", 9'h000, 0, 1, 3'd1, 3'd1, 0);
    press(0, 0, 1);
    check_all("nr_in_hold", 9'h010, 0, 0, 3'd1, 3'd1, 0);

    // Asynchronous reset during a left-win hold.
    repeat (5) press(1, 0, 0);
    check_all("win_l2", 9'h000, 1, 0, 3'd2, 3'd1, 0);
    #2 reset = 1'b0;
    #1;
    check_all("async_reset", 9'h010, 0, 0, 3'd0, 3'd0, 0);
    @(negedge clk) reset = 1'b1;
    idle(1);

    // Seven left wins end the match.
    for (int w = 1; w <= 7; w++) begin
      repeat (5) press(1, 0, 0);
      if (w < 7) begin
        check_all($sformatf("win%0d", w), 9'h000, 1, 0, 3'(w), 3'd0, 0);
        press(0, 0, 1);
        chk($sformatf("recentre%0d", w), 32'(bus.lights), 32'h010);
      end
    end
    check_all("match", 9'h1FF, 1, 0, 3'd7, 3'd0, 1);
    press(1, 0, 0); check_all("match_l", 9'h1FF, 1, 0, 3'd7, 3'd0, 1);
    press(0, 1, 0); check_all("match_r", 9'h1FF, 1, 0, 3'd7, 3'd0, 1);
    press(0, 0, 1); check_all("match_nr", 9'h1FF, 1, 0, 3'd7, 3'd0, 1);
    idle(20);       check_all("match_idle", 9'h1FF, 1, 0, 3'd7, 3'd0, 1);

    // Only reset leaves the match-over state.
    #2 reset = 1'b0;
    #1;
    check_all("match_reset", 9'h010, 0, 0, 3'd0, 3'd0, 0);
    @(negedge clk) reset = 1'b1;
    idle(2);
    check_all("final", 9'h010, 0, 0, 3'd0, 3'd0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
